rr_allocator: RTL and testbench
===============================

RR_ALLOCATOR -- requirements
Module: rr_allocator

Interface
REQ-001 The block SHALL take parameter N_IN, default 4: number of input ports, 2..16.
REQ-002 The block SHALL take parameter PORT_BITS, default 2: width of the routing field selecting an output port.
REQ-003 The block SHALL take parameter MAX_PKT_LEN, default 8: maximum phits per packet, head included, 2..255.
REQ-004 Port i_clk, input, 1 bit: chip clock; all state changes on its rising edge.
REQ-005 Port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port i_this_port, input, PORT_BITS: identity of the output port this allocator controls.
REQ-007 Port i_hdr, input, [N_IN][PORT_BITS+2]: top bits of each input phit; [PORT_BITS+1:PORT_BITS] is the type, [PORT_BITS-1:0] is the route field.
REQ-008 Port o_select, output, N_IN: one-hot (or zero) input-to-output connection.
REQ-009 Port o_shift, output, 1 bit: high when a head is granted this cycle; the datapath discards the consumed route field.
REQ-010 Port o_busy, output, 1 bit: registered, high while a packet owns the port.
REQ-011 Port o_owner, output, clog2(N_IN): registered index of the current owner; 0 when idle.
REQ-012 Port o_err, output, 1 bit: registered one-cycle pulse on a packet-length violation.

Function
REQ-013 Phit type encoding SHALL be: 2'b11 HEAD, 2'b10 PAYLOAD, anything else IDLE.
REQ-014 Input i SHALL request when its type is HEAD and its route field equals i_this_port.
REQ-015 The state machine SHALL have exactly two states, IDLE and BUSY; o_busy = (state == BUSY).
REQ-016 A packet SHALL continue in BUSY when i_hdr[owner] is PAYLOAD and len_cnt < MAX_PKT_LEN; o_select = onehot(owner) and o_shift = 0 in that cycle.
REQ-017 When continuing, len_cnt SHALL increment and the state SHALL stay BUSY.
REQ-018 The port SHALL be free in a cycle when the state is IDLE, or when in BUSY the owner's phit is not PAYLOAD, or when len_cnt == MAX_PKT_LEN.
REQ-019 When the port is free and there are requests, the grant SHALL go to the first requester at or cyclically after rr_ptr, in the same cycle (combinational).
REQ-020 On that grant, o_select = onehot(grant) and o_shift = 1.
REQ-021 At the next edge after a grant: state BUSY, owner = grant, rr_ptr = (grant+1) mod N_IN, len_cnt = 1.
REQ-022 When the port is free with no requests: o_select = 0 and o_shift = 0.
REQ-023 At the next edge after a free cycle with no requests: state IDLE, owner 0, len_cnt 0; rr_ptr is unchanged.
REQ-024 A release and a new grant in the same cycle SHALL lose no cycle; the released owner's new head competes at lowest priority.
REQ-025 When release is caused by len_cnt == MAX_PKT_LEN while the owner still presents PAYLOAD, o_err SHALL pulse high for one cycle at the next edge.
REQ-026 The excess PAYLOAD phits of an over-length packet SHALL never be granted.
REQ-027 o_select SHALL never have more than one bit set.
REQ-028 len_cnt SHALL be clog2(MAX_PKT_LEN+1) bits wide and SHALL never exceed MAX_PKT_LEN.

Reset
REQ-029 While i_rst_n is low: state IDLE, rr_ptr 0, owner 0, len_cnt 0, o_err 0, o_busy 0.
REQ-030 While i_rst_n is low, o_select and o_shift SHALL be forced to 0 regardless of i_hdr.
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately.
REQ-032 After reset deasserts, a PAYLOAD on the former owner SHALL not be granted.

Structure
REQ-033 Package alloc_pkg SHALL hold the phit type enum (HEAD, PAYLOAD, IDLE) and the state enum.
REQ-034 Package alloc_pkg SHALL hold the type-field width constant.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter: inputs request vector and pointer; outputs one-hot grant and index; purely combinational.

Verification (N_IN=4, PORT_BITS=2, MAX_PKT_LEN=8, i_this_port=2)
REQ-036 HEAD route 2 on inputs 0 and 1 simultaneously, rr_ptr 0: o_select=0001 and o_shift=1; next cycle o_busy=1, o_owner=0.
REQ-037 Input 0 sends 3 PAYLOAD then IDLE: o_select=0001 for 3 cycles; on IDLE, input 1 still heading gets o_select=0010 that same cycle.
REQ-038 Input 0 head followed by 10 PAYLOAD: select held for 8 phits; o_err pulses once after the 8th; payloads 9 and 10 see o_select=0000.
REQ-039 HEAD route 1 on all inputs: o_select=0000, o_shift=0, o_busy stays 0.
REQ-040 Inputs 0..3 all continuously issue single-phit packets: grants rotate 0,1,2,3,0 on consecutive cycles.
REQ-041 i_rst_n low mid-packet (len_cnt=4): outputs 0 immediately; after release with PAYLOAD still on input 0, o_select=0000.

Source files
------------

// File: rtl/alloc_pkg.sv
// Shared types for the output-port allocator: phit type decode and FSM states.
// The phit type sits in the top TYPE_W bits of each input header.
package alloc_pkg;

    localparam int TYPE_W = 2;

    typedef enum logic [TYPE_W-1:0] {
        PH_IDLE    = 2'b00,
        PH_PAYLOAD = 2'b10,
        PH_HEAD    = 2'b11
    } phit_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Any code other than HEAD or PAYLOAD is treated as an idle phit.
    function automatic phit_t decode_type(input logic [TYPE_W-1:0] t);
        case (t)
            2'b11:   return PH_HEAD;
            2'b10:   return PH_PAYLOAD;
            default: return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or cyclically after ptr_i.
// Produces the one-hot grant, its index and a valid flag.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rr_allocator.sv
// Output-port allocator: grants one input at a time a whole packet (head + payload),
// round-robin among heads routed here, and cuts off packets longer than MAX_PKT_LEN.
module rr_allocator
    import alloc_pkg::*;
#(
    parameter  int N_IN        = 4,
    parameter  int PORT_BITS   = 2,
    parameter  int MAX_PKT_LEN = 8,
    localparam int OW          = $clog2(N_IN),
    localparam int LW          = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [PORT_BITS-1:0]                   i_this_port,
    input  logic [N_IN-1:0][PORT_BITS+TYPE_W-1:0]  i_hdr,
    output logic [N_IN-1:0]                        o_select,
    output logic                                   o_shift,
    output logic                                   o_busy,
    output logic [OW-1:0]                          o_owner,
    output logic                                   o_err
);

    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_PKT_LEN);
    localparam logic [OW-1:0] LAST_IDX = OW'(N_IN - 1);

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q,   ptr_d;
    logic [LW-1:0]   len_q,   len_d;
    logic            err_q,   err_d;

    phit_t           ph_type [N_IN];
    logic [N_IN-1:0] req;
    logic [N_IN-1:0] arb_gnt;
    logic [OW-1:0]   arb_idx;
    logic            arb_valid;
    phit_t           owner_type;
    logic            cont;
    logic            overrun;
    logic [N_IN-1:0] owner_onehot;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_req
        assign ph_type[gi] = decode_type(i_hdr[gi][PORT_BITS+TYPE_W-1:PORT_BITS]);
        assign req[gi]     = (ph_type[gi] == PH_HEAD) &&
                             (i_hdr[gi][PORT_BITS-1:0] == i_this_port);
    end

    // rr_ptr already points past the last owner, so its new head competes last.
    rr_arbiter #(
        .N (N_IN)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign owner_type   = ph_type[owner_q];
    assign owner_onehot = N_IN'(1) << owner_q;
    assign cont    = (state_q == ST_BUSY) && (owner_type == PH_PAYLOAD) && (len_q < MAX_LEN);
    assign overrun = (state_q == ST_BUSY) && (owner_type == PH_PAYLOAD) && (len_q == MAX_LEN);

    always_comb begin
        o_select = '0;
        o_shift  = 1'b0;
        if (i_rst_n) begin
            if (cont) begin
                o_select = owner_onehot;
            end else if (arb_valid) begin
                o_select = arb_gnt;
                o_shift  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        err_d   = overrun;
        if (cont) begin
            state_d = ST_BUSY;
            len_d   = len_q + LW'(1);
        end else if (arb_valid) begin
            state_d = ST_BUSY;
            owner_d = arb_idx;
            ptr_d   = (arb_idx == LAST_IDX) ? '0 : arb_idx + OW'(1);
            len_d   = LW'(1);
        end else begin
            state_d = ST_IDLE;
            owner_d = '0;
            len_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign o_busy  = (state_q == ST_BUSY);
    assign o_owner = owner_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_rr_allocator.sv
// Bench for rr_allocator: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a packet-level reference model.
module tb_rr_allocator;

    localparam int N   = 4;
    localparam int PB  = 2;
    localparam int MAX = 8;

    localparam logic [3:0] H2 = 4'b1110;
    localparam logic [3:0] H1 = 4'b1101;
    localparam logic [3:0] PL = 4'b1000;
    localparam logic [3:0] ID = 4'b0000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [PB-1:0]         this_port = 2'd2;
    logic [N-1:0][PB+1:0]  hdr = '0;
    logic [N-1:0]          sel;
    logic                  shift;
    logic                  busy;
    logic [1:0]            owner;
    logic                  err;

    int n_cmp = 0;
    int n_bad = 0;

    rr_allocator #(.N_IN(N), .PORT_BITS(PB), .MAX_PKT_LEN(MAX)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_this_port (this_port),
        .i_hdr       (hdr),
        .o_select    (sel),
        .o_shift     (shift),
        .o_busy      (busy),
        .o_owner     (owner),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 3 = head, 2 = payload, 0 = anything else
    function automatic int ptype(input int i);
        logic [1:0] t;
        t = hdr[i][3:2];
        if (t == 2'b11) return 3;
        if (t == 2'b10) return 2;
        return 0;
    endfunction

    // Reference model: who owns the port, how many phits it has sent, where the
    // round-robin search starts.
    int m_busy = 0, m_owner = 0, m_ptr = 0, m_len = 0, m_err = 0;

    always @(negedge clk) begin : model_cmp
        int e_sel, e_shift, g, cont, over, j;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_len = 0; m_err = 0;
        end
        cont = (m_busy != 0) && ptype(m_owner) == 2 && m_len < MAX;
        over = (m_busy != 0) && ptype(m_owner) == 2 && m_len == MAX;
        e_sel = 0; e_shift = 0; g = -1;
        if (rst_n) begin
            if (cont) begin
                e_sel = 1 << m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && ptype(j) == 3 && hdr[j][1:0] == this_port) g = j;
                end
                if (g >= 0) begin
                    e_sel = 1 << g;
                    e_shift = 1;
                end
            end
        end
        chk("m_select", 32'(sel), e_sel);
        chk("m_shift", 32'(shift), e_shift);
        chk("m_busy", 32'(busy), m_busy);
        chk("m_owner", 32'(owner), m_owner);
        chk("m_err", 32'(err), m_err);
        if (rst_n) begin
            m_err = over;
            if (cont) begin
                m_len = m_len + 1;
            end else if (g >= 0) begin
                m_busy = 1; m_owner = g; m_ptr = (g + 1) % N; m_len = 1;
            end else begin
                m_busy = 0; m_owner = 0; m_len = 0;
            end
        end
    end

    task automatic drive(input logic [15:0] h, input logic r);
        @(posedge clk);
        #1;
        hdr   = h;
        rst_n = r;
    endtask

    initial begin : stim
        int held, errs, pay_pct, r;
        int rot [5];
        logic [15:0] h;
        rot = '{0, 1, 2, 3, 0};

        // reset state, heads ignored while in reset
        drive({ID, ID, H2, H2}, 1'b0);
        @(negedge clk); #1;
        chk("rst_select", 32'(sel), 0);
        chk("rst_shift", 32'(shift), 0);
        chk("rst_busy", 32'(busy), 0);

        // two heads, pointer at 0: input 0 wins
        drive({ID, ID, H2, H2}, 1'b1);
        @(negedge clk); #1;
        chk("first_grant_sel", 32'(sel), 4'b0001);
        chk("first_grant_shift", 32'(shift), 1);
        drive({ID, ID, H2, PL}, 1'b1);
        @(negedge clk); #1;
        chk("owner_busy", 32'(busy), 1);
        chk("owner_idx", 32'(owner), 0);
        chk("payload1_sel", 32'(sel), 4'b0001);
        chk("payload1_shift", 32'(shift), 0);
        repeat (2) begin
            drive({ID, ID, H2, PL}, 1'b1);
            @(negedge clk); #1;
            chk("payload_sel", 32'(sel), 4'b0001);
        end
        // input 0 releases, waiting head on input 1 granted in the same cycle
        drive({ID, ID, H2, ID}, 1'b1);
        @(negedge clk); #1;
        chk("handover_sel", 32'(sel), 4'b0010);
        chk("handover_shift", 32'(shift), 1);
        drive(16'h0, 1'b1);
        @(negedge clk); #1;
        chk("release_sel", 32'(sel), 0);
        drive(16'h0, 1'b1);
        @(negedge clk); #1;
        chk("idle_busy", 32'(busy), 0);

        // over-length packet: head + 10 payloads
        held = 0; errs = 0;
        drive({ID, ID, ID, H2}, 1'b1);
        @(negedge clk); #1;
        if (sel == 4'b0001) held++;
        for (int p = 1; p <= 10; p++) begin
            drive({ID, ID, ID, PL}, 1'b1);
            @(negedge clk); #1;
            if (sel == 4'b0001) held++;
            if (err) errs++;
            if (p == 10) chk("overlen_last_sel", 32'(sel), 0);
        end
        drive(16'h0, 1'b1);
        @(negedge clk); #1;
        if (err) errs++;
        chk("overlen_held", held, 8);
        chk("overlen_err_pulses", errs, 1);

        // heads routed elsewhere are ignored
        repeat (3) begin
            drive({H1, H1, H1, H1}, 1'b1);
            @(negedge clk); #1;
            chk("wrong_route_sel", 32'(sel), 0);
            chk("wrong_route_busy", 32'(busy), 0);
        end

        // single-phit packets on every input rotate the grant
        drive(16'h0, 1'b0);
        drive(16'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive({H2, H2, H2, H2}, 1'b1);
            @(negedge clk); #1;
            chk("rotate_sel", 32'(sel), 32'(1 << rot[k]));
        end

        // reset mid-packet abandons it
        drive({ID, ID, ID, H2}, 1'b1);
        repeat (3) drive({ID, ID, ID, PL}, 1'b1);
        @(negedge clk); #1;
        chk("pre_reset_busy", 32'(busy), 1);
        drive({ID, ID, ID, PL}, 1'b0);
        #1;
        chk("midrst_sel", 32'(sel), 0);
        chk("midrst_busy", 32'(busy), 0);
        drive({ID, ID, ID, PL}, 1'b1);
        @(negedge clk); #1;
        chk("postrst_sel", 32'(sel), 0);
        chk("postrst_busy", 32'(busy), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            pay_pct   = ((c / 500) % 2 == 1) ? 85 : 40;
            this_port = ((c / 500) % 3 == 2) ? 2'd1 : 2'd2;
            h = '0;
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(99);
                if (r < 20)
                    h[i*4 +: 4] = {2'b11, ($urandom_range(1) == 1) ? this_port : 2'($urandom_range(3))};
                else if (r < 20 + pay_pct)
                    h[i*4 +: 4] = {2'b10, 2'($urandom_range(3))};
                else
                    h[i*4 +: 4] = {1'b0, 1'($urandom_range(1)), 2'($urandom_range(3))};
            end
            drive(h, ($urandom_range(299) == 0) ? 1'b0 : 1'b1);
        end
        drive(16'h0, 1'b1);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
